// File: rtl/cfs_sync_debounce_pkg.sv
// -----------------------------------------------------------------------------
// cfs_sync_debounce_pkg
// Shared types and constants for the synchronizer/debouncer block.
//   cfs_dbnc_state_t   : debounce FSM state (IDLE / COUNT)
//   CFS_DBNC_GLITCH_W  : width of the optional rejected-glitch counter
//   CFS_DBNC_SYNC_MIN  : smallest legal synchronizer depth
// -----------------------------------------------------------------------------
package cfs_sync_debounce_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } cfs_dbnc_state_t;

    localparam int CFS_DBNC_GLITCH_W = 8;
    localparam int CFS_DBNC_SYNC_MIN = 2;

endpackage

// File: rtl/cfs_sync_chain.sv
// -----------------------------------------------------------------------------
// cfs_sync_chain
// Multi-flop synchronizer for one asynchronous level bit.
// Parameters:
//   STAGES    : number of flops in the chain (2..4)
//   RESET_VAL : value every flop takes during reset
// Ports:
//   clk     in   clock of the destination domain
//   reset_n in   asynchronous reset, active low
//   d       in   raw asynchronous level
//   cand    out  synchronized level (output of the last flop)
// -----------------------------------------------------------------------------
module cfs_sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic cand
);

    logic [STAGES-1:0] chain;

    // NOTE: every synchronizer flop is reset, so the first cand after release
    // is a defined value rather than whatever metastable residue was left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign cand = chain[STAGES-1];

endmodule

// File: rtl/cfs_sync_debounce.sv
// -----------------------------------------------------------------------------
// cfs_sync_debounce
// Synchronizes one asynchronous level into the clk domain and rejects pulses
// shorter than a programmable number of cycles.
// Optional feature macro: CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN adds a saturating
// rejected-glitch counter and its glitch_cnt port.
// Parameters:
//   SYNC_STAGES : synchronizer depth (2..4)
//   CNT_WIDTH   : width of debounce_cycles and of the stability counter
//   RESET_VAL   : reset value of the synchronizer and of data_sync
// Ports:
//   clk              in   clock
//   reset_n          in   asynchronous reset, active low
//   data_async       in   raw asynchronous level
//   debounce_cycles  in   required stable cycles (0 behaves as 1), quasi-static
//   data_sync        out  filtered synchronous level
//   changed          out  one-cycle pulse on the edge where data_sync toggles
//   busy             out  high while a candidate transition is being qualified
//   glitch_cnt       out  rejected-glitch count (macro builds only)
// -----------------------------------------------------------------------------
module cfs_sync_debounce
    import cfs_sync_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_WIDTH   = 4,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         data_async,
    input  logic [CNT_WIDTH-1:0]         debounce_cycles,
    output logic                         data_sync,
    output logic                         changed,
    output logic                         busy
`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [CFS_DBNC_GLITCH_W-1:0] glitch_cnt
`endif
);

    // Depths below the minimum cannot settle metastability; clamp upward.
    localparam int STAGES_EFF = (SYNC_STAGES < CFS_DBNC_SYNC_MIN) ? CFS_DBNC_SYNC_MIN
                                                                   : SYNC_STAGES;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    cfs_dbnc_state_t        state;
    logic [CNT_WIDTH-1:0]   counter;
    logic                   cand;
    logic [CNT_WIDTH-1:0]   thr;
    logic                   thr_is_one;
    logic [CNT_WIDTH:0]     cnt_inc;
    logic                   qualified;
    logic                   differs;

    cfs_sync_chain #(
        .STAGES    (STAGES_EFF),
        .RESET_VAL (RESET_VAL)
    ) u_sync_chain (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (data_async),
        .cand    (cand)
    );

    // A programmed zero means "accept after one cycle".
    assign thr        = (debounce_cycles == '0) ? CNT_ONE : debounce_cycles;
    assign thr_is_one = (thr == CNT_ONE);
    assign differs    = (cand != data_sync);

    // One extra bit so counter+1 can never wrap; the >= compare also lets a
    // lowered threshold qualify a transition already past it.
    assign cnt_inc   = {1'b0, counter} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign qualified = (cnt_inc >= {1'b0, thr});

    // NOTE: all state uses non-blocking assignments so every branch reads the
    // pre-edge values of state, counter and data_sync.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            counter   <= '0;
            data_sync <= RESET_VAL;
            changed   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (differs) begin
                        if (thr_is_one) begin
                            data_sync <= cand;
                            changed   <= 1'b1;
                            counter   <= '0;
                        end else begin
                            counter <= CNT_ONE;
                            busy    <= 1'b1;
                            state   <= COUNT;
                        end
                    end else begin
                        counter <= '0;
                    end
                end
                COUNT: begin
                    if (!differs) begin
                        // Candidate fell back before qualifying: a glitch.
                        counter <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (qualified) begin
                        data_sync <= cand;
                        changed   <= 1'b1;
                        counter   <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        counter <= cnt_inc[CNT_WIDTH-1:0];
                    end
                end
                default: begin
                    counter <= '0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic glitch;

    assign glitch = (state == COUNT) && !differs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt <= '0;
        end else if (glitch && (glitch_cnt != {CFS_DBNC_GLITCH_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cfs_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_cfs_sync_debounce
// Self-checking bench for cfs_sync_debounce. A reference model describes the
// filter as "the synchronized input must have disagreed with the output for
// at least thr consecutive edges"; each clock it pushes the expected outputs
// into a scoreboard queue that an independent monitor pops and compares.
// Directed sequences add latency and boundary checks; a random phase follows.
// Build with CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN defined to cover glitch_cnt.
// -----------------------------------------------------------------------------
module tb_cfs_sync_debounce;

    localparam int   S  = 2;
    localparam int   W  = 4;
    localparam logic RV = 1'b0;

    logic         clk;
    logic         reset_n;
    logic         data_async;
    logic [W-1:0] debounce_cycles;
    logic         data_sync;
    logic         changed;
    logic         busy;
`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]   glitch_cnt;
`endif

    int total = 0;
    int bad   = 0;

    cfs_sync_debounce #(
        .SYNC_STAGES (S),
        .CNT_WIDTH   (W),
        .RESET_VAL   (RV)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .data_async      (data_async),
        .debounce_cycles (debounce_cycles),
        .data_sync       (data_sync),
        .changed         (changed),
        .busy            (busy)
`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt      (glitch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit ds;
        bit ch;
        bit bsy;
        int glitch;
    } exp_t;

    exp_t sb[$];
    bit   hist[$];     // raw samples still travelling through the synchronizer
    bit   m_ds;
    int   m_run;       // consecutive edges the synchronized input disagreed
    int   m_glitch;

    always @(posedge clk) begin : model
        exp_t e;
        bit   c;
        int   thr;
        e.ch = 1'b0;
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i < S; i++) hist.push_back(RV);
            m_ds     = RV;
            m_run    = 0;
            m_glitch = 0;
        end else begin
            hist.push_back(data_async);
            c   = hist.pop_front();
            thr = (debounce_cycles == 0) ? 1 : int'(debounce_cycles);
            if (c != m_ds) begin
                m_run++;
                if (m_run >= thr) begin
                    m_ds  = c;
                    m_run = 0;
                    e.ch  = 1'b1;
                end
            end else begin
                if (m_run > 0 && m_glitch < 255) m_glitch++;
                m_run = 0;
            end
        end
        e.ds     = m_ds;
        e.bsy    = (m_run > 0);
        e.glitch = m_glitch;
        sb.push_back(e);
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got 0 entries expected 1 at %0t", $time);
        end else begin
            e = sb.pop_front();
            check("sb_data_sync", data_sync, e.ds);
            check("sb_changed", changed, e.ch);
            check("sb_busy", busy, e.bsy);
`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
            check("sb_glitch_cnt", glitch_cnt, e.glitch);
`endif
        end
    end

    // Counts edges until data_sync reaches want; -1 when the bound expires.
    task automatic edges_until(input logic want, input int limit, output int n);
        bit found;
        found = 1'b0;
        n     = 0;
        while (!found && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (data_sync === want) found = 1'b1;
        end
        if (!found) n = -1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int busy_seen;
        int ds_dropped;

        reset_n         = 1'b0;
        data_async      = 1'b0;
        debounce_cycles = 4'd4;
        repeat (3) @(negedge clk);
        #1;
        check("reset_data_sync", data_sync, RV);
        check("reset_changed", changed, 0);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0->1 step, thr=4: update exactly S+thr = 6 edges later
        data_async = 1'b1;
        edges_until(1'b1, 20, n);
        check("step_latency", n, 6);
        check("step_changed", changed, 1);
        @(posedge clk);
        #1;
        check("changed_drop", changed, 0);

        // 2-cycle 1->0 pulse with thr=4 is rejected
        @(negedge clk);
        data_async = 1'b0;
        busy_seen  = 0;
        ds_dropped = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) data_async = 1'b1;
            if (busy === 1'b1) busy_seen++;
            if (data_sync !== 1'b1) ds_dropped++;
        end
        check("glitch_busy_cycles", busy_seen, 2);
        check("glitch_ds_held", ds_dropped, 0);
`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_cnt_one", glitch_cnt, 1);
`endif

        // debounce_cycles=0 acts as thr=1: S+1 = 3 edges
        @(negedge clk);
        debounce_cycles = 4'd0;
        data_async      = 1'b0;
        edges_until(1'b0, 20, n);
        check("thr0_latency", n, 3);
        check("thr0_changed", changed, 1);

        // lower thr from 10 to 2 while counter=5: qualify on the next edge
        @(negedge clk);
        debounce_cycles = 4'd10;
        data_async      = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("lower_busy", busy, 1);
        check("lower_ds_before", data_sync, 0);
        debounce_cycles = 4'd2;
        @(posedge clk);
        #1;
        check("lower_ds_after", data_sync, 1);
        check("lower_changed", changed, 1);

        // reset mid-COUNT, then full latency with the input held
        @(negedge clk);
        debounce_cycles = 4'd2;
        data_async      = 1'b0;
        repeat (8) @(negedge clk);
        debounce_cycles = 4'd8;
        data_async      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
        check("pre_reset_glitch", glitch_cnt, 1);
`endif
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_data_sync", data_sync, RV);
        check("midreset_changed", changed, 0);
        check("midreset_busy", busy, 0);
`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
        check("midreset_glitch", glitch_cnt, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        edges_until(1'b1, 30, n);
        check("post_reset_latency", n, 10);

        // randomized phase, scored by the monitor
        for (int seg = 0; seg < 250; seg++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) debounce_cycles = 4'($urandom_range(0, 6));
            data_async = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 9)) @(negedge clk);
        end

`ifdef CFS_SYNC_DEBOUNCE_GLITCH_CNT_EN
        // 300 one-cycle glitches saturate the counter
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n         = 1'b1;
        debounce_cycles = 4'd4;
        data_async      = 1'b0;
        repeat (4) @(negedge clk);
        repeat (300) begin
            data_async = 1'b1;
            @(negedge clk);
            data_async = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("glitch_saturate", glitch_cnt, 8'hFF);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
